lsu_mem_initiator: RTL and testbench

- Initiator-side memory access unit that drives the single-port DPI-backed memory controller's valid/wen/addr/wdata/wmask interface and samples its rdata.
- Accepts one byte/half/word load or store from the core over a valid/ready request channel.
- Performs alignment, mask and data lane shifting on the way out, and extracts and extends load data on the way back.
- Returns a result on a valid/ready response channel. Exactly one access is outstanding at a time.

---
 rtl/lsu_mem_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one core request at a time, drives an aligned memory
// strobe for MEM_LATENCY cycles, and returns extended load data or an error response.
module lsu_mem_initiator #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_err;
    logic [7:0]  req_wmask;
    logic [31:0] req_wdata_masked;
    logic [31:0] req_wdata_lane;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    // Request decode: alignment check, byte mask and lane placement of store data.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_err          = 1'b0;
        req_wmask        = 8'h00;
        req_wdata_masked = 32'h0;
        case (req_size)
            2'd0: begin
                req_wmask        = 8'h01 << req_addr[1:0];
                req_wdata_masked = {24'h0, req_wdata[7:0]};
            end
            2'd1: begin
                req_err          = req_addr[0];
                req_wmask        = 8'h03 << req_addr[1:0];
                req_wdata_masked = {16'h0, req_wdata[15:0]};
            end
            2'd2: begin
                req_err          = |req_addr[1:0];
                req_wmask        = 8'h0F;
                req_wdata_masked = req_wdata;
            end
            default: req_err = 1'b1;
        endcase
        if (!req_wen) begin
            req_wmask = 8'h00;
        end
        req_wdata_lane = req_wen ? (req_wdata_masked << {req_addr[1:0], 3'b000}) : 32'h0;
    end

    // Load extraction from the latched offset/size of the outstanding access.
    always_comb begin
        rdata_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_data = {{24{~uns_q & rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1:    load_data = {{16{~uns_q & rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        mem_valid_d  = mem_valid_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d       = req_wen;
                    size_d      = req_size;
                    off_d       = req_addr[1:0];
                    uns_d       = req_unsigned;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = req_wdata_lane;
                    mem_wmask_d = req_wmask;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = CNT_INIT;
                        mem_valid_d = 1'b1;
                        mem_wen_d   = req_wen;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    mem_valid_d  = 1'b0;
                    mem_wen_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wen_q ? 32'h0 : load_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            uns_q        <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wmask_q  <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            mem_valid_q  <= mem_valid_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_valid  = mem_valid_q;
    assign mem_wen    = mem_wen_q;
    assign mem_raddr  = mem_addr_q;
    assign mem_waddr  = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: two instances (latency 1 and 3) with a behavioural memory,
// a directed vector table, hand-written corner sequences and a byte-level reference model.
module tb_lsu_mem_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_wen      [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];
    logic        mem_valid    [2];
    logic        mem_wen      [2];
    logic [31:0] mem_raddr    [2];
    logic [31:0] mem_waddr    [2];
    logic [31:0] mem_wdata    [2];
    logic [7:0]  mem_wmask    [2];
    logic [31:0] mem_rdata    [2];

    // Responder memory (64 words per instance) and the model's independent byte memory.
    logic [31:0] mem [2][64];
    logic [7:0]  mb  [2][256];
    bit          mem_init = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsu_mem_initiator #(.MEM_LATENCY(g == 0 ? 1 : 3)) dut (
            .clk          (clk),
            .reset        (reset[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_wen      (req_wen[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_err     (resp_err[g]),
            .mem_valid    (mem_valid[g]),
            .mem_wen      (mem_wen[g]),
            .mem_raddr    (mem_raddr[g]),
            .mem_waddr    (mem_waddr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wmask    (mem_wmask[g]),
            .mem_rdata    (mem_rdata[g])
        );
        assign mem_rdata[g] = mem_valid[g] ? mem[g][mem_raddr[g][7:2]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int g = 0; g < 2; g++) begin
                for (int w = 0; w < 64; w++) mem[g][w] = 32'h0;
                mem[g][4] = 32'h80F0_7F01;
            end
            mem_init = 1'b1;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (mem_valid[g] && mem_wen[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wmask[g][b]) mem[g][mem_waddr[g][7:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
                    end
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model: byte-granular memory, access size in bytes, plain arithmetic extension.
    function automatic void model(input int i, input bit wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                                  output bit err, output logic [31:0] rdata,
                                  output logic [7:0] wmask, output logic [31:0] wd);
        int     n;
        int     off;
        int     base;
        longint v;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        base  = int'(addr[7:2]) * 4;
        err   = (size == 2'd3) || ((off % n) != 0);
        rdata = 32'h0;
        wmask = 8'h00;
        wd    = 32'h0;
        if (err) return;
        if (wen) begin
            for (int b = 0; b < n; b++) begin
                wmask[off+b]       = 1'b1;
                wd[8*(off+b) +: 8] = wdata[8*b +: 8];
                mb[i][base+off+b]  = wdata[8*b +: 8];
            end
        end else begin
            v = 0;
            for (int b = 0; b < n; b++) v = v | (longint'(mb[i][base+off+b]) << (8*b));
            if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
            rdata = v[31:0];
        end
    endfunction

    // One full request/response transaction with protocol checks along the way.
    task automatic do_txn(input int i, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns, input int hold, input bit exp_err,
                          input string tag, output logic [31:0] rdata, output logic err,
                          output logic [31:0] waddr_s, output logic [31:0] wdata_s,
                          output logic [7:0] wmask_s);
        int lat_cfg;
        int nvalid;
        int lat;
        bit seen;
        bit first;
        bit win_bad;
        bit hold_bad;
        lat_cfg  = (i == 0) ? 1 : 3;
        nvalid   = 0;
        lat      = 1;
        seen     = 1'b0;
        first    = 1'b1;
        win_bad  = 1'b0;
        hold_bad = 1'b0;
        waddr_s  = 32'h0;
        wdata_s  = 32'h0;
        wmask_s  = 8'h00;
        rdata    = 32'h0;
        err      = 1'b0;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(req_ready[i]), 32'd1);
        req_valid[i]    = 1'b1;
        req_wen[i]      = wen;
        req_addr[i]     = addr;
        req_wdata[i]    = wdata;
        req_size[i]     = size;
        req_unsigned[i] = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_addr[i]  = $urandom();
        req_wdata[i] = $urandom();
        for (int c = 0; c < 40 && !seen; c++) begin
            if (resp_valid[i]) begin
                seen = 1'b1;
            end else begin
                if (mem_valid[i]) begin
                    if (first) begin
                        waddr_s = mem_waddr[i];
                        wdata_s = mem_wdata[i];
                        wmask_s = mem_wmask[i];
                        first   = 1'b0;
                        if (mem_raddr[i] !== mem_waddr[i]) win_bad = 1'b1;
                    end else if (mem_waddr[i] !== waddr_s || mem_wdata[i] !== wdata_s ||
                                 mem_wmask[i] !== wmask_s) begin
                        win_bad = 1'b1;
                    end
                    if (mem_wen[i] !== wen) win_bad = 1'b1;
                    nvalid++;
                end
                if (req_ready[i] !== 1'b0) win_bad = 1'b1;
                lat++;
                @(negedge clk);
            end
        end
        check({tag, " response seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, lat, exp_err ? 1 : lat_cfg + 1);
        check({tag, " strobe cycles"}, nvalid, exp_err ? 0 : lat_cfg);
        check({tag, " strobe window"}, 32'(win_bad), 32'd0);
        if (seen) begin
            rdata = resp_rdata[i];
            err   = resp_err[i];
            if (mem_valid[i] !== 1'b0 || req_ready[i] !== 1'b0) hold_bad = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (resp_valid[i] !== 1'b1 || resp_rdata[i] !== rdata || resp_err[i] !== err ||
                    req_ready[i] !== 1'b0 || mem_valid[i] !== 1'b0) hold_bad = 1'b1;
            end
            check({tag, " resp hold"}, 32'(hold_bad), 32'd0);
            resp_ready[i] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready[i] = 1'b0;
            check({tag, " after handshake"},
                  {29'h0, resp_valid[i], req_ready[i], mem_valid[i]}, 32'b010);
        end
    endtask

    typedef struct {
        int          inst;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          uns;
        int          hold;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          chk_mem;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    vec_t vecs [13];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd, wa, wdd, exp_rd, exp_wd;
        logic [7:0]  wm, exp_wm;
        logic        er;
        bit          e;
        int          i, resp_seen;
        bit          wen, uns;
        logic [31:0] addr, wdata;
        logic [1:0]  size;

        for (int g = 0; g < 2; g++) begin
            reset[g]        = 1'b1;
            req_valid[g]    = 1'b0;
            req_wen[g]      = 1'b0;
            req_addr[g]     = 32'h0;
            req_wdata[g]    = 32'h0;
            req_size[g]     = 2'd0;
            req_unsigned[g] = 1'b0;
            resp_ready[g]   = 1'b0;
            for (int b = 0; b < 256; b++) mb[g][b] = 8'h00;
            mb[g][16] = 8'h01;
            mb[g][17] = 8'h7F;
            mb[g][18] = 8'hF0;
            mb[g][19] = 8'h80;
        end

        //            inst wen addr          wdata         sz uns hold exp_rdata     err chk waddr         wdata         wmask
        vecs[0]  = '{0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 2, 0, 0, 32'h0000_0000, 0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F};
        vecs[1]  = '{0, 0, 32'h8000_0004, 32'h0,         2, 0, 0, 32'hDEAD_BEEF, 0, 1, 32'h8000_0004, 32'h0000_0000, 8'h00};
        vecs[2]  = '{0, 1, 32'h8000_0003, 32'h0000_00A5, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h8000_0000, 32'hA500_0000, 8'h08};
        vecs[3]  = '{0, 0, 32'h8000_0011, 32'h0,         0, 0, 1, 32'h0000_007F, 0, 0, 32'h0,         32'h0,         8'h00};
        vecs[4]  = '{0, 0, 32'h8000_0012, 32'h0,         0, 0, 0, 32'hFFFF_FFF0, 0, 0, 32'h0,         32'h0,         8'h00};
        vecs[5]  = '{0, 0, 32'h8000_0012, 32'h0,         1, 0, 0, 32'hFFFF_80F0, 0, 0, 32'h0,         32'h0,         8'h00};
        vecs[6]  = '{0, 0, 32'h8000_0012, 32'h0,         1, 1, 2, 32'h0000_80F0, 0, 0, 32'h0,         32'h0,         8'h00};
        vecs[7]  = '{0, 0, 32'h8000_0001, 32'h0,         1, 0, 0, 32'h0000_0000, 1, 0, 32'h0,         32'h0,         8'h00};
        vecs[8]  = '{0, 0, 32'h8000_0000, 32'h0,         3, 0, 1, 32'h0000_0000, 1, 0, 32'h0,         32'h0,         8'h00};
        vecs[9]  = '{1, 1, 32'h8000_0022, 32'hFFFF_1234, 1, 0, 4, 32'h0000_0000, 0, 1, 32'h8000_0020, 32'h1234_0000, 8'h0C};
        vecs[10] = '{1, 0, 32'h8000_0020, 32'h0,         2, 0, 4, 32'h1234_0000, 0, 1, 32'h8000_0020, 32'h0000_0000, 8'h00};
        vecs[11] = '{1, 1, 32'h8000_0006, 32'h1111_2222, 2, 0, 0, 32'h0000_0000, 1, 0, 32'h0,         32'h0,         8'h00};
        vecs[12] = '{1, 0, 32'h8000_0013, 32'h0,         0, 1, 0, 32'h0000_0080, 0, 0, 32'h0,         32'h0,         8'h00};

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("i%0d reset resp", g),
                  {30'h0, resp_valid[g], resp_err[g]}, 32'h0);
            check($sformatf("i%0d reset resp_rdata", g), resp_rdata[g], 32'h0);
            check($sformatf("i%0d reset mem strobe", g),
                  {22'h0, mem_valid[g], mem_wen[g], mem_wmask[g]}, 32'h0);
            check($sformatf("i%0d reset mem addr", g), mem_waddr[g], 32'h0);
            check($sformatf("i%0d reset mem wdata", g), mem_wdata[g], 32'h0);
            check($sformatf("i%0d reset req_ready", g), 32'(req_ready[g]), 32'd1);
            reset[g] = 1'b0;
        end

        for (int k = 0; k < 13; k++) begin
            model(vecs[k].inst, vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].size,
                  vecs[k].uns, e, exp_rd, exp_wm, exp_wd);
            do_txn(vecs[k].inst, vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].size,
                   vecs[k].uns, vecs[k].hold, vecs[k].exp_err, $sformatf("v%0d", k),
                   rd, er, wa, wdd, wm);
            check($sformatf("v%0d rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("v%0d err", k), 32'(er), 32'(vecs[k].exp_err));
            if (vecs[k].chk_mem) begin
                check($sformatf("v%0d mem_waddr", k), wa, vecs[k].exp_waddr);
                check($sformatf("v%0d mem_wdata", k), wdd, vecs[k].exp_wdata);
                check($sformatf("v%0d mem_wmask", k), 32'(wm), 32'(vecs[k].exp_wmask));
            end
        end

        // Reset during the second strobe cycle of a latency-3 store.
        @(negedge clk);
        req_valid[1]    = 1'b1;
        req_wen[1]      = 1'b1;
        req_addr[1]     = 32'h8000_0028;
        req_wdata[1]    = 32'h1122_3344;
        req_size[1]     = 2'd2;
        req_unsigned[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rst first strobe", 32'(mem_valid[1]), 32'd1);
        @(negedge clk);
        check("rst second strobe", 32'(mem_valid[1]), 32'd1);
        reset[1] = 1'b1;
        @(negedge clk);
        check("rst abort state", {29'h0, mem_valid[1], resp_valid[1], req_ready[1]}, 32'b001);
        reset[1] = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid[1] || mem_valid[1]) resp_seen++;
        end
        check("rst no response", resp_seen, 0);
        model(1, 1'b1, 32'h8000_0028, 32'h1122_3344, 2'd2, 1'b0, e, exp_rd, exp_wm, exp_wd);
        do_txn(1, 1'b0, 32'h8000_0028, 32'h0, 2'd2, 1'b0, 1, 1'b0, "rst reload",
               rd, er, wa, wdd, wm);
        check("rst reload rdata", rd, 32'h1122_3344);

        // Randomized traffic against the byte-level model.
        for (int n = 0; n < 200; n++) begin
            int r;
            i     = $urandom_range(0, 1);
            wen   = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 9);
            size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr  = 32'h8000_0000 | ($urandom() & 32'hFF);
            wdata = $urandom();
            model(i, wen, addr, wdata, size, uns, e, exp_rd, exp_wm, exp_wd);
            do_txn(i, wen, addr, wdata, size, uns, $urandom_range(0, 2), e,
                   $sformatf("r%0d", n), rd, er, wa, wdd, wm);
            check($sformatf("r%0d rdata", n), rd, exp_rd);
            check($sformatf("r%0d err", n), 32'(er), 32'(e));
            if (!e) begin
                check($sformatf("r%0d mem_waddr", n), wa, {addr[31:2], 2'b00});
                check($sformatf("r%0d mem_wdata", n), wdd, exp_wd);
                check($sformatf("r%0d mem_wmask", n), 32'(wm), 32'(exp_wm));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
